rsa_host_sequencer: RTL and testbench

Host-side command initiator for the RSA accelerator's ARM↔FPGA command/data protocol. It accepts one job (mode plus five 1024-bit operands) from a local producer. It then drives the full command sequence into the accelerator wrapper: five READ transfers, one ENCRYPT/DECRYPT, and one WRITE fetch, with a done/done-read handshake after each. The result is returned on a valid/ready output. It sits between a local job source (test harness or bus bridge) and the accelerator's command port, replacing software polling.

---
 rtl/rsa_if_pkg.sv | 32 +++
 rtl/rsa_done_handshake.sv | 64 ++++++
 rtl/rsa_host_sequencer.sv | 152 +++++++++++++++
 tb/tb_rsa_host_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_if_pkg.sv
// Shared definitions for the RSA accelerator host command protocol.
// Command codes, operand geometry and host sequencer state encodings.
package rsa_if_pkg;

  localparam int DATA_W       = 1024;
  localparam int NUM_OPERANDS = 5;

  localparam logic [31:0] CMD_READ    = 32'h0;
  localparam logic [31:0] CMD_ENCRYPT = 32'h1;
  localparam logic [31:0] CMD_WRITE   = 32'h2;
  localparam logic [31:0] CMD_DECRYPT = 32'h3;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE    = 4'd0;
  localparam seq_state_t ST_OP_WAIT = 4'd1;
  localparam seq_state_t ST_RD_CMD  = 4'd2;
  localparam seq_state_t ST_RD_DATA = 4'd3;
  localparam seq_state_t ST_EX_CMD  = 4'd4;
  localparam seq_state_t ST_WR_CMD  = 4'd5;
  localparam seq_state_t ST_WR_DATA = 4'd6;
  localparam seq_state_t ST_HS      = 4'd7;
  localparam seq_state_t ST_RESULT  = 4'd8;

  // Where the done handshake returns once it completes.
  typedef enum logic [1:0] {
    RET_RD = 2'd0,
    RET_EX = 2'd1,
    RET_WR = 2'd2
  } hs_ret_t;

endpackage

// File: rtl/rsa_done_handshake.sv
// Done handshake: wait done high, pulse done_read once, wait done low; finished/timeout are
// combinational in the completing cycle. Each wait is bounded by TIMEOUT_CYCLES.
module rsa_done_handshake #(
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  output logic done_read,
  output logic finished,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] H_IDLE    = 2'd0;
  localparam logic [1:0] H_WAIT_HI = 2'd1;
  localparam logic [1:0] H_WAIT_LO = 2'd2;

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CNT_LAST);
  assign finished = (st == H_WAIT_LO) && !done;
  assign timeout  = at_limit && (((st == H_WAIT_HI) && !done) || ((st == H_WAIT_LO) && done));

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= H_IDLE;
      cnt       <= '0;
      done_read <= 1'b0;
    end else begin
      done_read <= 1'b0;
      case (st)
        H_IDLE: begin
          if (start) begin
            st  <= H_WAIT_HI;
            cnt <= '0;
          end
        end
        H_WAIT_HI: begin
          if (done) begin
            st        <= H_WAIT_LO;
            cnt       <= '0;
            done_read <= 1'b1;
          end else if (at_limit) begin
            st <= H_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        H_WAIT_LO: begin
          // Releasing only on done low guarantees a quiet cycle before the next command.
          if (!done || at_limit) st <= H_IDLE;
          else                   cnt <= cnt + 1'b1;
        end
        default: st <= H_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rsa_host_sequencer.sv
// Host command initiator: one job = 5 READs, ENCRYPT/DECRYPT, WRITE, each closed by a done handshake.
// Job/operand inputs stall via job_ready/op_ready; result held on res_valid until res_ready.
module rsa_host_sequencer #(
  parameter int DATA_W         = rsa_if_pkg::DATA_W,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic              job_decrypt,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              error,
  output logic [31:0]       arm_to_fpga_cmd,
  output logic              arm_to_fpga_cmd_valid,
  output logic              arm_to_fpga_data_valid,
  input  logic              arm_to_fpga_data_ready,
  output logic [DATA_W-1:0] arm_to_fpga_data,
  input  logic              fpga_to_arm_done,
  output logic              fpga_to_arm_done_read,
  input  logic              fpga_to_arm_data_valid,
  output logic              fpga_to_arm_data_ready,
  input  logic [DATA_W-1:0] fpga_to_arm_data
);
  import rsa_if_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t        state, state_nxt;
  hs_ret_t           ret;
  logic [2:0]        op_idx;
  logic              decrypt;
  logic [DATA_W-1:0] op_reg, res_reg;
  logic [31:0]       cmd_reg;
  logic              error_reg;
  logic [CW-1:0]     tcnt;
  logic              wait_expired, abort;
  logic              hs_start, hs_finished, hs_timeout;

  assign wait_expired = (tcnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (job_valid) state_nxt = ST_OP_WAIT;
      ST_OP_WAIT: if (op_valid) state_nxt = ST_RD_CMD;
      ST_RD_CMD:  state_nxt = ST_RD_DATA;
      ST_RD_DATA: begin
        if (arm_to_fpga_data_ready) state_nxt = ST_HS;
        else if (wait_expired)      state_nxt = ST_IDLE;
      end
      ST_EX_CMD:  state_nxt = ST_HS;
      ST_WR_CMD:  state_nxt = ST_WR_DATA;
      ST_WR_DATA: begin
        if (fpga_to_arm_data_valid) state_nxt = ST_HS;
        else if (wait_expired)      state_nxt = ST_IDLE;
      end
      ST_HS: begin
        if (hs_timeout) begin
          state_nxt = ST_IDLE;
        end else if (hs_finished) begin
          case (ret)
            RET_RD:  state_nxt = (op_idx < 3'(NUM_OPERANDS - 1)) ? ST_OP_WAIT : ST_EX_CMD;
            RET_EX:  state_nxt = ST_WR_CMD;
            default: state_nxt = ST_RESULT;
          endcase
        end
      end
      ST_RESULT:  if (res_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // The only routes back to IDLE from a wait state are expired waits.
  assign abort    = (state_nxt == ST_IDLE) &&
                    ((state == ST_RD_DATA) || (state == ST_WR_DATA) || (state == ST_HS));
  assign hs_start = (state != ST_HS) && (state_nxt == ST_HS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ret       <= RET_RD;
      op_idx    <= '0;
      decrypt   <= 1'b0;
      op_reg    <= '0;
      res_reg   <= '0;
      cmd_reg   <= '0;
      error_reg <= 1'b0;
      tcnt      <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) tcnt <= '0;
      else                    tcnt <= tcnt + 1'b1;

      if (state == ST_IDLE && job_valid) begin
        decrypt   <= job_decrypt;
        op_idx    <= '0;
        error_reg <= 1'b0;
      end
      if (abort) error_reg <= 1'b1;

      if (state_nxt == ST_RD_CMD) begin
        op_reg  <= op_data;
        cmd_reg <= CMD_READ;
        ret     <= RET_RD;
      end
      if (state_nxt == ST_EX_CMD) begin
        cmd_reg <= decrypt ? CMD_DECRYPT : CMD_ENCRYPT;
        ret     <= RET_EX;
      end
      if (state_nxt == ST_WR_CMD) begin
        cmd_reg <= CMD_WRITE;
        ret     <= RET_WR;
      end

      if (state == ST_HS && hs_finished && ret == RET_RD) op_idx <= op_idx + 1'b1;
      if (state == ST_WR_DATA && fpga_to_arm_data_valid) res_reg <= fpga_to_arm_data;
    end
  end

  rsa_done_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hs (
    .clk       (clk),
    .reset     (reset),
    .start     (hs_start),
    .done      (fpga_to_arm_done),
    .done_read (fpga_to_arm_done_read),
    .finished  (hs_finished),
    .timeout   (hs_timeout)
  );

  assign job_ready              = (state == ST_IDLE);
  assign busy                   = (state != ST_IDLE);
  assign op_ready               = (state == ST_OP_WAIT);
  assign res_valid              = (state == ST_RESULT);
  assign res_data               = res_reg;
  assign error                  = error_reg;
  assign arm_to_fpga_cmd        = cmd_reg;
  assign arm_to_fpga_cmd_valid  = (state == ST_RD_CMD) || (state == ST_EX_CMD) || (state == ST_WR_CMD);
  assign arm_to_fpga_data_valid = (state == ST_RD_DATA);
  assign arm_to_fpga_data       = op_reg;
  assign fpga_to_arm_data_ready = (state == ST_WR_DATA) && fpga_to_arm_data_valid;

endmodule

// File: tb/tb_rsa_host_sequencer.sv
// Bench for rsa_host_sequencer: accelerator responder model plus scoreboards for command codes,
// operand order and results.
`timescale 1ns/1ps
module tb_rsa_host_sequencer;
  import rsa_if_pkg::*;

  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              job_valid, job_ready, job_decrypt;
  logic              op_valid, op_ready;
  logic [DATA_W-1:0] op_data;
  logic              res_valid, res_ready;
  logic [DATA_W-1:0] res_data;
  logic              busy, error;
  logic [31:0]       arm_to_fpga_cmd;
  logic              arm_to_fpga_cmd_valid, arm_to_fpga_data_valid, arm_to_fpga_data_ready;
  logic [DATA_W-1:0] arm_to_fpga_data;
  logic              fpga_to_arm_done, fpga_to_arm_done_read;
  logic              fpga_to_arm_data_valid, fpga_to_arm_data_ready;
  logic [DATA_W-1:0] fpga_to_arm_data;

  always #5 clk = ~clk;

  rsa_host_sequencer #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_decrypt(job_decrypt),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .error(error),
    .arm_to_fpga_cmd(arm_to_fpga_cmd), .arm_to_fpga_cmd_valid(arm_to_fpga_cmd_valid),
    .arm_to_fpga_data_valid(arm_to_fpga_data_valid), .arm_to_fpga_data_ready(arm_to_fpga_data_ready),
    .arm_to_fpga_data(arm_to_fpga_data),
    .fpga_to_arm_done(fpga_to_arm_done), .fpga_to_arm_done_read(fpga_to_arm_done_read),
    .fpga_to_arm_data_valid(fpga_to_arm_data_valid), .fpga_to_arm_data_ready(fpga_to_arm_data_ready),
    .fpga_to_arm_data(fpga_to_arm_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] modexp(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    logic [63:0] r;
    r = 64'd1;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  logic [31:0] cmd_q[$];
  logic [63:0] op_q[$];
  logic [63:0] res_q[$];

  // Responder knobs and monitor counters.
  int extra_hold = 0;
  bit never_done = 1'b0;
  bit stall_ready = 1'b0;
  int cmd_cnt = 0, done_read_cnt = 0, res_seen = 0, consec_viol = 0, cmd_while_done = 0;

  initial begin
    logic [63:0] rx[5];
    logic [63:0] result;
    int rx_idx, compute, hold;
    bit rd_ack, wr_ack, pc, pd, pf;
    arm_to_fpga_data_ready = 1'b0;
    fpga_to_arm_done = 1'b0;
    fpga_to_arm_data_valid = 1'b0;
    fpga_to_arm_data = '0;
    rx = '{default: 64'd0};
    result = '0;
    rx_idx = 0; compute = 0; hold = 0;
    rd_ack = 0; wr_ack = 0; pc = 0; pd = 0; pf = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        arm_to_fpga_data_ready = 1'b0;
        fpga_to_arm_done = 1'b0;
        fpga_to_arm_data_valid = 1'b0;
        rx_idx = 0; compute = 0; hold = 0;
        rd_ack = 0; wr_ack = 0; pc = 0; pd = 0; pf = 0;
        continue;
      end
      if ((arm_to_fpga_cmd_valid && pc) || (fpga_to_arm_done_read && pd) || (fpga_to_arm_data_ready && pf))
        consec_viol++;
      pc = arm_to_fpga_cmd_valid;
      pd = fpga_to_arm_done_read;
      pf = fpga_to_arm_data_ready;
      if (arm_to_fpga_cmd_valid && fpga_to_arm_done) cmd_while_done++;
      if (res_valid) res_seen++;
      if (fpga_to_arm_done_read) done_read_cnt++;

      if (fpga_to_arm_done_read) begin
        if (extra_hold == 0) fpga_to_arm_done = 1'b0;
        else hold = extra_hold;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) fpga_to_arm_done = 1'b0;
      end

      if (compute > 0) begin
        compute--;
        if (compute == 0) fpga_to_arm_done = 1'b1;
      end

      if (rd_ack) begin
        arm_to_fpga_data_ready = 1'b0;
        rd_ack = 0;
        fpga_to_arm_done = 1'b1;
      end else if (arm_to_fpga_data_valid && !stall_ready) begin
        arm_to_fpga_data_ready = 1'b1;
        rd_ack = 1;
        if (op_q.size() == 0) check("op_q_size", 64'(op_q.size()), 64'd1);
        else check("op_order", arm_to_fpga_data[63:0], op_q.pop_front());
        if (rx_idx < 5) rx[rx_idx] = arm_to_fpga_data[63:0];
        rx_idx++;
      end

      if (arm_to_fpga_cmd_valid) begin
        cmd_cnt++;
        if (cmd_q.size() == 0) check("cmd_q_size", 64'(cmd_q.size()), 64'd1);
        else check("cmd_code", 64'(arm_to_fpga_cmd), 64'(cmd_q.pop_front()));
        if (arm_to_fpga_cmd == CMD_ENCRYPT || arm_to_fpga_cmd == CMD_DECRYPT) begin
          result = modexp(rx[0], rx[1], rx[2]);
          rx_idx = 0;
          if (!never_done) compute = 10;
        end else if (arm_to_fpga_cmd == CMD_WRITE) begin
          fpga_to_arm_data_valid = 1'b1;
          fpga_to_arm_data = DATA_W'(result);
        end
      end

      if (wr_ack) begin
        fpga_to_arm_data_valid = 1'b0;
        wr_ack = 0;
        fpga_to_arm_done = 1'b1;
      end else if (fpga_to_arm_data_ready) begin
        wr_ack = 1;
      end
    end
  end

  task automatic submit(input bit dec, input logic [63:0] o0, input logic [63:0] o1,
                        input logic [63:0] o2, input logic [63:0] o3, input logic [63:0] o4);
    logic [63:0] ops[5];
    int n;
    ops = '{o0, o1, o2, o3, o4};
    for (int i = 0; i < 5; i++) begin
      cmd_q.push_back(CMD_READ);
      op_q.push_back(ops[i]);
    end
    cmd_q.push_back(dec ? CMD_DECRYPT : CMD_ENCRYPT);
    cmd_q.push_back(CMD_WRITE);
    res_q.push_back(modexp(o0, o1, o2));
    @(negedge clk);
    job_valid = 1'b1;
    job_decrypt = dec;
    n = 0;
    while (!job_ready && n < 200) begin @(negedge clk); n++; end
    check("job_ready_wait_ok", 64'(n < 200), 64'd1);
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    check("error_cleared_on_accept", 64'(error), 64'd0);
    for (int i = 0; i < 5; i++) begin
      op_valid = 1'b1;
      op_data = DATA_W'(ops[i]);
      n = 0;
      while (!op_ready && n < 400) begin @(negedge clk); n++; end
      check("op_ready_wait_ok", 64'(n < 400), 64'd1);
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
    end
  endtask

  task automatic collect(input int hold_cycles, output logic [63:0] got);
    logic [DATA_W-1:0] cap;
    int n, unstable;
    n = 0;
    while (!res_valid && n < 2000) begin @(negedge clk); n++; end
    check("res_wait_ok", 64'(n < 2000), 64'd1);
    got = res_data[63:0];
    if (res_q.size() == 0) check("res_q_size", 64'(res_q.size()), 64'd1);
    else check("res_data", res_data[63:0], res_q.pop_front());
    check("res_data_upper_zero", 64'(|res_data[DATA_W-1:64]), 64'd0);
    cap = res_data;
    unstable = 0;
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      if (!res_valid || res_data !== cap || job_ready) unstable++;
    end
    check("res_hold_stable", 64'(unstable), 64'd0);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_dropped", 64'(res_valid), 64'd0);
    check("job_ready_after_result", 64'(job_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [63:0] got;
    int n, wait_cnt;
    reset = 1'b1;
    job_valid = 1'b0; job_decrypt = 1'b0;
    op_valid = 1'b0; op_data = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_job_ready", 64'(job_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_op_ready", 64'(op_ready), 64'd0);
    check("rst_cmd", 64'(arm_to_fpga_cmd), 64'd0);
    check("rst_strobes", 64'({arm_to_fpga_cmd_valid, arm_to_fpga_data_valid,
                              fpga_to_arm_done_read, fpga_to_arm_data_ready}), 64'd0);
    check("rst_data_out", 64'(|arm_to_fpga_data), 64'd0);
    check("rst_res_data", 64'(|res_data), 64'd0);
    reset = 1'b0;

    // Encrypt 5^3 mod 33; 125 mod 33 is 26 decimal. r mod n = 2^1024 mod 33 = 16, r^2 mod n = 25.
    cmd_cnt = 0; done_read_cnt = 0;
    submit(1'b0, 64'd5, 64'd3, 64'd33, 64'd16, 64'd25);
    collect(0, got);
    check("enc_result", got, 64'd26);
    check("enc_cmd_count", 64'(cmd_cnt), 64'd7);
    check("enc_done_read_count", 64'(done_read_cnt), 64'd7);

    // Decrypt with d=7 recovers 5; done held 3 extra cycles, consumer stalls 20 cycles.
    extra_hold = 3;
    cmd_cnt = 0; done_read_cnt = 0; cmd_while_done = 0;
    submit(1'b1, 64'd26, 64'd7, 64'd33, 64'd16, 64'd25);
    collect(20, got);
    check("dec_result", got, 64'd5);
    check("dec_cmd_count", 64'(cmd_cnt), 64'd7);
    check("dec_done_read_once_per_phase", 64'(done_read_cnt), 64'd7);
    check("no_cmd_while_done_high", 64'(cmd_while_done), 64'd0);
    extra_hold = 0;

    // Accelerator never signals done after EX.
    never_done = 1'b1;
    res_seen = 0;
    submit(1'b0, 64'd7, 64'd3, 64'd33, 64'd16, 64'd25);
    n = 0;
    while (!(arm_to_fpga_cmd_valid && arm_to_fpga_cmd == CMD_ENCRYPT) && n < 200) begin
      @(negedge clk); n++;
    end
    check("ex_strobe_seen", 64'(n < 200), 64'd1);
    wait_cnt = 0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (error) break;
      wait_cnt++;
    end
    check("timeout_wait_cycles", 64'(wait_cnt), 64'd64);
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_idle", 64'({job_ready, busy}), 64'b10);
    check("timeout_no_res_valid", 64'(res_seen), 64'd0);
    cmd_q.delete();
    res_q.delete();
    never_done = 1'b0;
    submit(1'b0, 64'd2, 64'd5, 64'd33, 64'd16, 64'd25);
    collect(0, got);
    check("recover_result", got, 64'd32);
    check("recover_error_low", 64'(error), 64'd0);

    // Reset while the sequencer is holding an operand in RD_DATA.
    stall_ready = 1'b1;
    cmd_q.push_back(CMD_READ);
    @(negedge clk);
    job_valid = 1'b1;
    job_decrypt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    op_valid = 1'b1;
    op_data = DATA_W'(64'h9);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (!arm_to_fpga_data_valid && n < 50) begin @(negedge clk); n++; end
    check("rd_data_reached", 64'(arm_to_fpga_data_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_strobes", 64'({arm_to_fpga_cmd_valid, arm_to_fpga_data_valid,
                                 fpga_to_arm_done_read, fpga_to_arm_data_ready}), 64'd0);
    check("midrst_job_ready", 64'(job_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    stall_ready = 1'b0;
    cmd_q.delete();
    op_q.delete();

    submit(1'b0, 64'd4, 64'd3, 64'd33, 64'd16, 64'd25);
    collect(0, got);
    check("post_reset_result", got, 64'd31);
    check("strobe_never_consecutive", 64'(consec_viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
